// File: rtl/bitserial_input_streamer.sv
`default_nettype none
// ============================================================================
// Module   : bitserial_input_streamer
// Brief    : Streams one LANES-wide activation vector as MSB-first bit-planes,
//            each vector preceded by a one-cycle start_acc pulse. A one-entry
//            holding buffer lets the next vector load while the current one
//            streams. Optional feature macro: SIGNED_INPUT_EN (two's
//            complement activations, MSB plane flagged negative).
// Revision : 1.0 - initial release
// ============================================================================
module bitserial_input_streamer #(
    parameter int LANES    = 32,
    parameter int IN_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*IN_WIDTH-1:0]    in_data,
    input  logic                         stall,
    output logic                         start_acc,
    output logic                         plane_valid,
    output logic [LANES-1:0]             plane_bits,
    output logic [$clog2(IN_WIDTH)-1:0]  plane_idx,
    output logic                         last_plane,
    output logic                         plane_neg,
    output logic                         busy
);

    localparam int                 c_IDX_W   = $clog2(IN_WIDTH);
    localparam int                 c_VEC_W   = LANES * IN_WIDTH;
    localparam logic [c_IDX_W-1:0] c_CNT_MSB = c_IDX_W'(IN_WIDTH - 1);
    localparam logic [c_IDX_W-1:0] c_CNT_ONE = c_IDX_W'(1);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_START  = 2'd1;
    localparam logic [1:0] c_S_STREAM = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_IDX_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] w_cnt_nxt;
    logic [c_VEC_W-1:0] r_hold;
    logic [c_VEC_W-1:0] r_work;
    logic               r_hold_full;
    logic               w_take;
    logic               w_load;
    logic               w_streaming;

    // A full buffer never accepts, so a take and a load cannot coincide.
    assign w_take      = in_valid && !r_hold_full;
    assign w_streaming = (r_state == c_S_STREAM);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (r_hold_full && !stall) begin
                    w_state_nxt = c_S_START;
                    w_load      = 1'b1;
                    w_cnt_nxt   = c_CNT_MSB;
                end
            end
            c_S_START: begin
                if (!stall) begin
                    w_state_nxt = c_S_STREAM;
                end
            end
            c_S_STREAM: begin
                if (!stall) begin
                    if (r_cnt == '0) begin
                        if (r_hold_full) begin
                            w_state_nxt = c_S_START;
                            w_load      = 1'b1;
                            w_cnt_nxt   = c_CNT_MSB;
                        end else begin
                            w_state_nxt = c_S_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - c_CNT_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_take) begin
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    // Data registers need no reset: every output is qualified by state.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_hold <= in_data;
        end
        if (w_load) begin
            r_work <= r_hold;
        end
    end

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic [IN_WIDTH-1:0] w_lane;
            assign w_lane        = r_work[k*IN_WIDTH +: IN_WIDTH];
            assign plane_bits[k] = w_streaming && w_lane[r_cnt];
        end
    endgenerate

    assign in_ready    = !r_hold_full;
    assign start_acc   = (r_state == c_S_START);
    assign plane_valid = w_streaming;
    assign plane_idx   = w_streaming ? r_cnt : '0;
    assign last_plane  = w_streaming && (r_cnt == '0);
    assign busy        = (r_state != c_S_IDLE) || r_hold_full;

`ifdef SIGNED_INPUT_EN
    assign plane_neg = w_streaming && (r_cnt == c_CNT_MSB);
`else
    assign plane_neg = 1'b0;
`endif

endmodule
`default_nettype wire
